// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and default constants for the buffered UART TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned c_DIV_DEFAULT       = 868;
    localparam int unsigned c_STOP_BITS_DEFAULT = 1;
    localparam int unsigned c_BAUD_W            = 16;
    localparam int unsigned c_BIT_IDX_W         = 3;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with registered occupancy count; full/empty are
//            decoded from the count register only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned       c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wr_ptr_q;
    logic [c_AW-1:0]  rd_ptr_q;
    logic [c_AW:0]    count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o     = (count_q == c_FULL);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign w_push     = push_i & ~full_o;
    assign w_pop      = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buf.sv
// ============================================================================
// Module   : uart_tx_buf
// Purpose  : FIFO-buffered UART transmitter (8 data bits, 1 or 2 stop bits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned DIV        = c_DIV_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned STOP_BITS  = c_STOP_BITS_DEFAULT
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          wr_valid_i,
    input  logic [7:0]                    wr_data_i,
    output logic                          wr_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

    localparam logic [c_BAUD_W-1:0]    c_BAUD_RELOAD = c_BAUD_W'(DIV - 1);
    localparam logic [c_BIT_IDX_W-1:0] c_LAST_STOP   = c_BIT_IDX_W'(STOP_BITS - 1);
    localparam logic [c_BIT_IDX_W-1:0] c_LAST_DATA   = c_BIT_IDX_W'(7);

    tx_state_e               state_q,   state_d;
    logic [c_BAUD_W-1:0]     baud_q,    baud_d;
    logic [c_BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [7:0]              shift_q,   shift_d;
    logic                    tx_q,      tx_d;

    logic                    w_fifo_pop;
    logic [7:0]              w_fifo_data;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_baud_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (wr_valid_i),
        .push_data_i (wr_data_i),
        .pop_i       (w_fifo_pop),
        .pop_data_o  (w_fifo_data),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (fifo_cnt_o)
    );

    assign wr_ready_o  = ~w_fifo_full;
    assign tx_o        = tx_q;
    assign busy_o      = (state_q != IDLE) | ~w_fifo_empty;
    assign w_baud_done = (baud_q == '0);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        w_fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!w_fifo_empty) begin
                    w_fifo_pop = 1'b1;
                    shift_d    = w_fifo_data;
                    state_d    = START;
                    tx_d       = 1'b0;
                    baud_d     = c_BAUD_RELOAD;
                end
            end
            START: begin
                if (w_baud_done) begin
                    state_d   = DATA;
                    baud_d    = c_BAUD_RELOAD;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    baud_d    = c_BAUD_RELOAD;
                    // 3-bit index wraps 7 -> 0 as the frame leaves DATA.
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == c_LAST_DATA) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    if (bit_idx_q == c_LAST_STOP) begin
                        bit_idx_d = '0;
                        if (!w_fifo_empty) begin
                            // Chain straight into the next frame with no idle gap.
                            w_fifo_pop = 1'b1;
                            shift_d    = w_fifo_data;
                            state_d    = START;
                            tx_d       = 1'b0;
                            baud_d     = c_BAUD_RELOAD;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                            baud_d  = '0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        baud_d    = c_BAUD_RELOAD;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

`default_nettype wire
